// File: rtl/l2_prefetch_fill.sv
// l2_prefetch_fill: line fill engine feeding the L2 prefetch buffer write port.
// Fetches one line critical-word-first with wrap inside the line, forwards the
// critical longword for early cycle termination, and can chain one fill of the
// next sequential line.
module l2_prefetch_fill #(
  parameter int AW        = 28,
  parameter int LINE_LOG2 = 2,
  parameter bit PF_NEXT   = 1'b1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          MissReq,
  input  logic [AW-1:0] MissA,
  input  logic          Abort,
  output logic          Busy,
  output logic          MB_REQ,
  output logic [AW-1:0] MB_A,
  input  logic          MB_ACK,
  input  logic [31:0]   MB_D,
  output logic          WR,
  output logic [AW-1:0] WRA,
  output logic [31:0]   WRD,
  output logic [3:0]    WRM,
  output logic          CritValid,
  output logic [31:0]   CritD
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_NEXT  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  localparam logic [LINE_LOG2-1:0] LAST_WORD = {LINE_LOG2{1'b1}};
  localparam logic [AW-1:0]        LINE_INC  = {{(AW-1){1'b0}}, 1'b1} << LINE_LOG2;

  state_t               state_q, state_d;
  logic [AW-1:0]        base_q, base_d;
  logic [LINE_LOG2-1:0] offset_q, offset_d;
  logic [LINE_LOG2-1:0] count_q, count_d;
  logic                 crit_pend_q, crit_pend_d;
  logic                 demand_q, demand_d;
  logic                 busy_q, busy_d;
  logic                 mb_req_q, mb_req_d;
  logic [AW-1:0]        mb_a_q, mb_a_d;
  logic                 wr_q, wr_d;
  logic [AW-1:0]        wra_q, wra_d;
  logic [31:0]          wrd_q, wrd_d;
  logic [3:0]           wrm_q, wrm_d;
  logic                 crit_valid_q, crit_valid_d;
  logic [31:0]          crit_data_q, crit_data_d;
  logic [LINE_LOG2-1:0] word_idx_s;

  // Word index within the line; the narrow add wraps so it never carries into base.
  always_comb begin
    word_idx_s = offset_q + count_q;
  end

  // Next-state and registered-output computation for the fill sequencer.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    offset_d     = offset_q;
    count_d      = count_q;
    crit_pend_d  = crit_pend_q;
    demand_d     = demand_q;
    mb_req_d     = mb_req_q;
    mb_a_d       = mb_a_q;
    wr_d         = 1'b0;
    wra_d        = wra_q;
    wrd_d        = wrd_q;
    wrm_d        = 4'b0000;
    crit_valid_d = 1'b0;
    crit_data_d  = crit_data_q;

    case (state_q)
      ST_IDLE: begin
        if (MissReq) begin
          base_d      = {MissA[AW-1:LINE_LOG2], {LINE_LOG2{1'b0}}};
          offset_d    = MissA[LINE_LOG2-1:0];
          count_d     = {LINE_LOG2{1'b0}};
          crit_pend_d = 1'b1;
          demand_d    = 1'b1;
          state_d     = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REQ: begin
        if (Abort) begin
          // No request is outstanding yet, so nothing needs draining.
          state_d = ST_IDLE;
        end else begin
          mb_req_d = 1'b1;
          mb_a_d   = base_q | {{(AW-LINE_LOG2){1'b0}}, word_idx_s};
          state_d  = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (Abort) begin
          if (MB_ACK) begin
            // Ack arriving with the abort is simply dropped.
            mb_req_d = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            // Keep the bus request up until the bus completes it.
            state_d = ST_DRAIN;
          end
        end else if (MB_ACK) begin
          mb_req_d = 1'b0;
          wr_d     = 1'b1;
          wra_d    = mb_a_q;
          wrd_d    = MB_D;
          wrm_d    = 4'b1111;
          if (crit_pend_q) begin
            crit_valid_d = 1'b1;
            crit_data_d  = MB_D;
            crit_pend_d  = 1'b0;
          end else begin
            crit_pend_d = 1'b0;
          end
          count_d = count_q + {{(LINE_LOG2-1){1'b0}}, 1'b1};
          if (count_q == LAST_WORD) begin
            state_d = ST_NEXT;
          end else begin
            state_d = ST_REQ;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_NEXT: begin
        if (!Abort && (PF_NEXT == 1'b1) && demand_q) begin
          base_d   = base_q + LINE_INC;
          offset_d = {LINE_LOG2{1'b0}};
          count_d  = {LINE_LOG2{1'b0}};
          demand_d = 1'b0;
          state_d  = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_DRAIN: begin
        if (MB_ACK) begin
          mb_req_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end

      default: begin
        mb_req_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      base_q       <= {AW{1'b0}};
      offset_q     <= {LINE_LOG2{1'b0}};
      count_q      <= {LINE_LOG2{1'b0}};
      crit_pend_q  <= 1'b0;
      demand_q     <= 1'b0;
      busy_q       <= 1'b0;
      mb_req_q     <= 1'b0;
      mb_a_q       <= {AW{1'b0}};
      wr_q         <= 1'b0;
      wra_q        <= {AW{1'b0}};
      wrd_q        <= 32'h0000_0000;
      wrm_q        <= 4'b0000;
      crit_valid_q <= 1'b0;
      crit_data_q  <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      offset_q     <= offset_d;
      count_q      <= count_d;
      crit_pend_q  <= crit_pend_d;
      demand_q     <= demand_d;
      busy_q       <= busy_d;
      mb_req_q     <= mb_req_d;
      mb_a_q       <= mb_a_d;
      wr_q         <= wr_d;
      wra_q        <= wra_d;
      wrd_q        <= wrd_d;
      wrm_q        <= wrm_d;
      crit_valid_q <= crit_valid_d;
      crit_data_q  <= crit_data_d;
    end
  end

  assign Busy      = busy_q;
  assign MB_REQ    = mb_req_q;
  assign MB_A      = mb_a_q;
  assign WR        = wr_q;
  assign WRA       = wra_q;
  assign WRD       = wrd_q;
  assign WRM       = wrm_q;
  assign CritValid = crit_valid_q;
  assign CritD     = crit_data_q;

endmodule

// File: tb/tb_l2_prefetch_fill.sv
// Bench for l2_prefetch_fill: a cycle table for a plain demand fill, then
// scripted sequences for chaining, top-of-memory wrap, abort and reset.
module tb_l2_prefetch_fill;

  logic        clk = 1'b0;
  logic [1:0]  rst, miss_req, abort, mb_ack;
  logic [27:0] miss_a [2];
  logic [31:0] mb_d   [2];
  logic [1:0]  busy, mb_req, wr, crit_valid;
  logic [27:0] mb_a [2];
  logic [27:0] wra  [2];
  logic [31:0] wrd  [2];
  logic [3:0]  wrm  [2];
  logic [31:0] crit_d [2];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Instance 0 fetches demand lines only; instance 1 chains the next line.
  l2_prefetch_fill #(.AW(28), .LINE_LOG2(2), .PF_NEXT(1'b0)) dut0 (
    .CLK(clk), .RST(rst[0]), .MissReq(miss_req[0]), .MissA(miss_a[0]), .Abort(abort[0]),
    .Busy(busy[0]), .MB_REQ(mb_req[0]), .MB_A(mb_a[0]), .MB_ACK(mb_ack[0]), .MB_D(mb_d[0]),
    .WR(wr[0]), .WRA(wra[0]), .WRD(wrd[0]), .WRM(wrm[0]),
    .CritValid(crit_valid[0]), .CritD(crit_d[0]));

  l2_prefetch_fill #(.AW(28), .LINE_LOG2(2), .PF_NEXT(1'b1)) dut1 (
    .CLK(clk), .RST(rst[1]), .MissReq(miss_req[1]), .MissA(miss_a[1]), .Abort(abort[1]),
    .Busy(busy[1]), .MB_REQ(mb_req[1]), .MB_A(mb_a[1]), .MB_ACK(mb_ack[1]), .MB_D(mb_d[1]),
    .WR(wr[1]), .WRA(wra[1]), .WRD(wrd[1]), .WRM(wrm[1]),
    .CritValid(crit_valid[1]), .CritD(crit_d[1]));

  typedef struct {
    logic        miss;
    logic [27:0] ma;
    logic        ack;
    logic [31:0] d;
    logic [127:0] exp;  // {Busy, MB_REQ, MB_A, WR, WRA, WRD, WRM, CritValid, CritD}
  } vec_t;

  vec_t tbl [19];

  logic [27:0] reqs [$];
  logic [27:0] wrs  [$];
  logic [27:0] exp_q [$];
  int          n_crit;
  logic [31:0] crit_seen;
  int          ack_cyc;
  int          idle_cyc;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic miss, input logic [27:0] ma, input logic ack,
                              input logic [31:0] d, input logic b, input logic rq,
                              input logic [27:0] a, input logic w, input logic [27:0] wa,
                              input logic [31:0] wd, input logic [3:0] wm, input logic cv,
                              input logic [31:0] cd);
    vec_t v;
    v.miss = miss; v.ma = ma; v.ack = ack; v.d = d;
    v.exp  = {b, rq, a, w, wa, wd, wm, cv, cd};
    return v;
  endfunction

  function automatic logic [31:0] pat(input logic [27:0] a);
    return {4'hA, a};
  endfunction

  // Expected critical-word-first order, optionally followed by the next line.
  task automatic build_exp(input logic [27:0] ma, input bit chained);
    logic [27:0] base;
    logic [1:0]  off;
    exp_q.delete();
    base = {ma[27:2], 2'b00};
    off  = ma[1:0];
    for (int i = 0; i < 4; i++) exp_q.push_back(base | {26'd0, off + 2'(i)});
    if (chained) begin
      base = base + 28'd4;
      for (int i = 0; i < 4; i++) exp_q.push_back(base | 28'(i));
    end
  endtask

  task automatic cmp_list(input string name);
    chk({name, "_nreq"}, 128'(reqs.size()), 128'(exp_q.size()));
    chk({name, "_nwr"},  128'(wrs.size()),  128'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < reqs.size()) chk($sformatf("%s_req%0d", name, i), 128'(reqs[i]), 128'(exp_q[i]));
      if (i < wrs.size())  chk($sformatf("%s_wr%0d", name, i),  128'(wrs[i]),  128'(exp_q[i]));
    end
  endtask

  // amode: 0 none, 1 abort when request #aword appears (ack 3 cycles in), 2 abort with its ack.
  task automatic run_fill(input int d, input logic [27:0] ma, input int amode,
                          input int aword, input bit pulse);
    int cnt, nreq, lat;
    reqs.delete(); wrs.delete();
    n_crit = 0; crit_seen = 32'h0; ack_cyc = -1; idle_cyc = -1;
    cnt = 0; nreq = 0; lat = 2;
    @(negedge clk);
    miss_req[d] = 1'b1; miss_a[d] = ma;
    for (int cyc = 1; cyc < 400; cyc++) begin
      @(negedge clk);
      miss_req[d] = 1'b0; abort[d] = 1'b0; mb_ack[d] = 1'b0;
      if (busy[d] == 1'b0) begin
        idle_cyc = cyc;
        break;
      end
      chk("wrm_vs_wr", 128'(wrm[d]), wr[d] ? 128'(4'hF) : 128'(4'h0));
      if (wr[d]) begin
        wrs.push_back(wra[d]);
        chk("wrd", 128'(wrd[d]), 128'(pat(wra[d])));
      end
      if (crit_valid[d]) begin
        n_crit++;
        crit_seen = crit_d[d];
      end
      if (pulse && (cyc % 3 == 0)) begin
        miss_req[d] = 1'b1; miss_a[d] = 28'h0ABCDE5;
      end
      if (mb_req[d]) begin
        if (cnt == 0) begin
          reqs.push_back(mb_a[d]);
          nreq++;
          lat = 2;
          if (amode == 1 && nreq == aword) begin
            abort[d] = 1'b1;
            lat = 3;
          end
        end
        cnt++;
        if (cnt == lat) begin
          mb_ack[d] = 1'b1; mb_d[d] = pat(mb_a[d]); cnt = 0; ack_cyc = cyc;
          if (amode == 2 && nreq == aword) abort[d] = 1'b1;
        end
      end
    end
    miss_req[d] = 1'b0; abort[d] = 1'b0; mb_ack[d] = 1'b0;
    if (idle_cyc < 0) begin
      n_bad++;
      $display("FAIL timeout: engine %0d still busy, expected IDLE within budget", d);
    end
  endtask

  initial begin
    rst = 2'b11; miss_req = 2'b00; abort = 2'b00; mb_ack = 2'b00;
    for (int i = 0; i < 2; i++) begin miss_a[i] = 28'h0; mb_d[i] = 32'h0; end

    // Demand fill on PF_NEXT=0, MissA=0x103, ack on the third MB_REQ cycle.
    tbl[0]  = mk(1'b1, 28'h103, 1'b0, 32'h0,  1'b0, 1'b0, 28'h0,   1'b0, 28'h0,   32'h0,  4'h0, 1'b0, 32'h0);
    tbl[1]  = mk(1'b0, 28'h0,   1'b0, 32'h0,  1'b1, 1'b0, 28'h0,   1'b0, 28'h0,   32'h0,  4'h0, 1'b0, 32'h0);
    tbl[2]  = mk(1'b0, 28'h0,   1'b0, 32'h0,  1'b1, 1'b1, 28'h103, 1'b0, 28'h0,   32'h0,  4'h0, 1'b0, 32'h0);
    tbl[3]  = tbl[2];
    tbl[4]  = mk(1'b0, 28'h0,   1'b1, 32'hA3, 1'b1, 1'b1, 28'h103, 1'b0, 28'h0,   32'h0,  4'h0, 1'b0, 32'h0);
    tbl[5]  = mk(1'b0, 28'h0,   1'b0, 32'h0,  1'b1, 1'b0, 28'h103, 1'b1, 28'h103, 32'hA3, 4'hF, 1'b1, 32'hA3);
    tbl[6]  = mk(1'b0, 28'h0,   1'b0, 32'h0,  1'b1, 1'b1, 28'h100, 1'b0, 28'h103, 32'hA3, 4'h0, 1'b0, 32'hA3);
    tbl[7]  = tbl[6];
    tbl[8]  = mk(1'b0, 28'h0,   1'b1, 32'hA0, 1'b1, 1'b1, 28'h100, 1'b0, 28'h103, 32'hA3, 4'h0, 1'b0, 32'hA3);
    tbl[9]  = mk(1'b0, 28'h0,   1'b0, 32'h0,  1'b1, 1'b0, 28'h100, 1'b1, 28'h100, 32'hA0, 4'hF, 1'b0, 32'hA3);
    tbl[10] = mk(1'b0, 28'h0,   1'b0, 32'h0,  1'b1, 1'b1, 28'h101, 1'b0, 28'h100, 32'hA0, 4'h0, 1'b0, 32'hA3);
    tbl[11] = tbl[10];
    tbl[12] = mk(1'b0, 28'h0,   1'b1, 32'hA1, 1'b1, 1'b1, 28'h101, 1'b0, 28'h100, 32'hA0, 4'h0, 1'b0, 32'hA3);
    tbl[13] = mk(1'b0, 28'h0,   1'b0, 32'h0,  1'b1, 1'b0, 28'h101, 1'b1, 28'h101, 32'hA1, 4'hF, 1'b0, 32'hA3);
    tbl[14] = mk(1'b0, 28'h0,   1'b0, 32'h0,  1'b1, 1'b1, 28'h102, 1'b0, 28'h101, 32'hA1, 4'h0, 1'b0, 32'hA3);
    tbl[15] = tbl[14];
    tbl[16] = mk(1'b0, 28'h0,   1'b1, 32'hA2, 1'b1, 1'b1, 28'h102, 1'b0, 28'h101, 32'hA1, 4'h0, 1'b0, 32'hA3);
    tbl[17] = mk(1'b0, 28'h0,   1'b0, 32'h0,  1'b1, 1'b0, 28'h102, 1'b1, 28'h102, 32'hA2, 4'hF, 1'b0, 32'hA3);
    tbl[18] = mk(1'b0, 28'h0,   1'b0, 32'h0,  1'b0, 1'b0, 28'h102, 1'b0, 28'h102, 32'hA2, 4'h0, 1'b0, 32'hA3);

    repeat (3) @(negedge clk);
    rst = 2'b00;

    for (int i = 0; i < 19; i++) begin
      chk($sformatf("demand_row%0d", i),
          {busy[0], mb_req[0], mb_a[0], wr[0], wra[0], wrd[0], wrm[0], crit_valid[0], crit_d[0]},
          tbl[i].exp);
      miss_req[0] = tbl[i].miss; miss_a[0] = tbl[i].ma;
      mb_ack[0]   = tbl[i].ack;  mb_d[0]   = tbl[i].d;
      @(negedge clk);
    end
    miss_req[0] = 1'b0; mb_ack[0] = 1'b0;

    // Chained prefetch from 0x101.
    run_fill(1, 28'h0000101, 0, 0, 1'b0);
    build_exp(28'h0000101, 1'b1);
    cmp_list("chain");
    chk("chain_ncrit", 128'(n_crit), 128'(1));
    chk("chain_critd", 128'(crit_seen), 128'(pat(28'h0000101)));

    // Wrap at the top of the address space into line 0.
    run_fill(1, 28'hFFFFFFE, 0, 0, 1'b0);
    exp_q = '{28'hFFFFFFE, 28'hFFFFFFF, 28'hFFFFFFC, 28'hFFFFFFD,
              28'h0000000, 28'h0000001, 28'h0000002, 28'h0000003};
    cmp_list("wrap");
    chk("wrap_critd", 128'(crit_seen), 128'(pat(28'hFFFFFFE)));

    // Abort while the third request is outstanding; ack lands 3 cycles later.
    run_fill(1, 28'h0000200, 1, 3, 1'b0);
    chk("abort_nreq", 128'(reqs.size()), 128'(3));
    chk("abort_nwr", 128'(wrs.size()), 128'(2));
    chk("abort_idle", 128'(idle_cyc), 128'(ack_cyc + 1));
    chk("abort_ncrit", 128'(n_crit), 128'(1));

    // Abort coincident with the ack of the second word.
    run_fill(0, 28'h0000302, 2, 2, 1'b0);
    chk("abort_ack_nreq", 128'(reqs.size()), 128'(2));
    chk("abort_ack_nwr", 128'(wrs.size()), 128'(1));
    chk("abort_ack_idle", 128'(idle_cyc), 128'(ack_cyc + 1));

    // MissReq pulses while busy must be ignored.
    run_fill(0, 28'h0000346, 0, 0, 1'b1);
    build_exp(28'h0000346, 1'b0);
    cmp_list("busy_miss");
    chk("busy_miss_ncrit", 128'(n_crit), 128'(1));
    repeat (4) @(negedge clk);
    chk("busy_miss_quiet", 128'({busy[0], mb_req[0]}), 128'(2'b00));

    // Reset while waiting for an ack, then a stray ack.
    miss_req[0] = 1'b1; miss_a[0] = 28'h0000208;
    @(negedge clk); miss_req[0] = 1'b0;
    @(negedge clk);
    chk("rst_pre_req", 128'(mb_req[0]), 128'(1));
    rst[0] = 1'b1;
    @(negedge clk); rst[0] = 1'b0;
    chk("rst_outputs", 128'({busy[0], mb_req[0], mb_a[0], wr[0], wrm[0], crit_valid[0]}), 128'(0));
    mb_ack[0] = 1'b1; mb_d[0] = 32'hDEADBEEF;
    @(negedge clk); mb_ack[0] = 1'b0;
    chk("rst_stray_ack", 128'({busy[0], mb_req[0], wr[0], wrd[0], crit_valid[0], crit_d[0]}), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/l2_prefetch_fill.md
Name: l2_prefetch_fill

Overview:
- Fill engine directly upstream of the L2 prefetch buffer. On a CPU read miss to cacheable RAM, it fetches one line from the motherboard bus and writes each longword into the prefetch buffer's write port (WRA/WRD/WR/WRM).
- Fetch order is critical-word-first with wrap within the line. The critical longword is also forwarded so the STERM logic can terminate the stalled CPU cycle early.
- Optionally chains a fetch of the next sequential line.

Parameters:
- AW, 28, longword address width; matches the prefetch buffer WRA width.
- LINE_LOG2, 2, log2 of longwords per line (default 4 longwords = 16 bytes).
- PF_NEXT, 1, when 1, a completed demand line is followed by a fill of the next sequential line.

Ports:
- CLK  in  1  FSB clock; all logic rising-edge.
- RST  in  1  synchronous reset, active-high.
- MissReq  in  1  request a fill; sampled only in IDLE.
- MissA  in  AW  longword address of the missed access.
- Abort  in  1  cancel current fill (e.g. snooped write to the line).
- Busy  out  1  engine not in IDLE.
- MB_REQ  out  1  motherboard longword read request.
- MB_A  out  AW  longword address for MB_REQ.
- MB_ACK  in  1  one-cycle acknowledge; MB_D valid this cycle.
- MB_D  in  32  read data.
- WR  out  1  prefetch buffer write strobe, one cycle per longword.
- WRA  out  AW  prefetch buffer write address.
- WRD  out  32  prefetch buffer write data.
- WRM  out  4  byte mask; always 4'b1111 when WR=1, 4'b0000 otherwise.
- CritValid  out  1  one-cycle pulse: critical longword available.
- CritD  out  32  critical longword data, valid with CritValid.

Behaviour:
- Decided: one clock; reset is synchronous and active-high (ports CLK, RST).
- Reset values: Busy=0, MB_REQ=0, MB_A=0, WR=0, WRA=0, WRD=0, WRM=0, CritValid=0, CritD=0; state IDLE.
- States: IDLE, REQ, WAIT, NEXT, DRAIN.
- IDLE:
  - MissReq=1 latches base = MissA with low LINE_LOG2 bits cleared, and offset = MissA low bits.
  - Clears count, sets the crit flag, goes to REQ; Busy=1 from the next cycle.
  - MissReq outside IDLE is ignored; the requester must retry.
- REQ:
  - Drive MB_REQ=1, MB_A = base | ((offset+count) mod 2^LINE_LOG2).
  - Go to WAIT in the same cycle; MB_REQ is registered and held until ACK.
- WAIT:
  - MB_REQ and MB_A stay stable until the MB_ACK cycle.
  - On MB_ACK, the next cycle gives: MB_REQ=0; WR=1, WRA=MB_A, WRD=MB_D, WRM=4'b1111.
  - If the crit flag is set, the same cycle also gives CritValid=1 and CritD=MB_D, and the crit flag clears.
  - count increments.
  - If count was the last word of the line (2^LINE_LOG2 - 1), go to NEXT; otherwise go to REQ.
  - This gives a minimum of 2 cycles per longword (REQ/ACK turnaround).
- NEXT:
  - If PF_NEXT=1 and the current line was a demand line: base += 2^LINE_LOG2 (wraps modulo 2^AW), offset=0, count=0, crit flag stays clear, go to REQ.
  - Otherwise go to IDLE.
  - Only one chained line per miss.
- Abort:
  - In REQ or WAIT: no further requests are issued. If MB_REQ is already high, go to DRAIN and wait for MB_ACK; that data is discarded (WR stays 0, no CritValid). Then go to IDLE.
  - In NEXT: go to IDLE.
  - In IDLE: no effect.
  - Abort and MB_ACK in the same cycle: data is discarded, and the engine goes directly to IDLE.
- Words already written before Abort remain in the buffer; invalidating them is the snoop logic's job.
- RST mid-fill: all outputs return to reset values next cycle, including MB_REQ=0. No WR occurs for an in-flight ACK.
- WR, CritValid: never asserted for more than one cycle per ACK.
- Address arithmetic: offset wrap is modulo 2^LINE_LOG2 and never carries into base.

Test Plan:
- Demand fill, PF_NEXT=0: MissA=0x0000103, MB_ACK 2 cycles after each MB_REQ, MB_D=0xA0+addr low nibble -> MB_A order 0x103, 0x100, 0x101, 0x102. WR four times with matching WRA/WRD, WRM=4'hF. CritValid exactly once with CritD=0xA3. Busy drops after the last WR.
- Chained prefetch, PF_NEXT=1: MissA=0x0000101 -> after the wrap 101, 102, 103, 100, the engine continues 104, 105, 106, 107. CritValid only once, for 0x101. Returns to IDLE after 8 WRs.
- Address wrap at top: MissA=0xFFFFFFE, PF_NEXT=1 -> demand order FFFFFFE, FFFFFFF, FFFFFFC, FFFFFFD, then next line 0000000..0000003.
- Abort mid-line: Abort asserted while MB_REQ=1 for the 3rd word, MB_ACK 3 cycles later -> exactly 2 WRs. The ACKed 3rd word is not written. No further MB_REQ. IDLE the cycle after ACK.
- Miss while busy, plus reset: MissReq pulses during a fill -> ignored, no extra requests. RST asserted in WAIT -> next cycle MB_REQ=0, Busy=0, WR=0; a subsequent MB_ACK causes no write.
